// File: rtl/proc_trace_buffer_if.sv
// Drain side of the write-trace buffer: head entry with valid/ready handshake.
// The buffer drives the head entry; the consumer answers with out_ready.
interface proc_trace_buffer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int TS_W   = 16
);
    logic              out_valid;
    logic              out_ready;
    logic              out_is_mem;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;

    modport master (
        output out_valid, out_is_mem, out_addr, out_data, out_ts,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_is_mem, out_addr, out_data, out_ts,
        output out_ready
    );
endinterface

// File: rtl/proc_trace_buffer.sv
// Timestamped capture of register-file and data-memory writes into a circular
// buffer, drained through a valid/ready port. Up to two pushes and one pop per cycle.
module proc_trace_buffer #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 3,
    parameter int MEM_AW    = 8,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         clear,
    input  logic                         reg_we,
    input  logic [REG_AW-1:0]            reg_waddr,
    input  logic [DATA_W-1:0]            reg_wdata,
    input  logic                         mem_we,
    input  logic [MEM_AW-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_wdata,
    proc_trace_buffer_if.master          trc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [1:0]                   state,
    output logic                         overflow
);
    localparam int ADDR_W = (REG_AW > MEM_AW) ? REG_AW : MEM_AW;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'b00, CAPTURE = 2'b01, STOPPED = 2'b10} state_t;

    typedef struct packed {
        logic              is_mem;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          buf_q [DEPTH];
    entry_t          out_q;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [TS_W-1:0]  ts_q;

    logic             pop, r_ev, m_ev, acc_r, acc_m, drop, ovf_set, full_stop, wr0, wr1;
    logic [1:0]       n_push, n_ovw;
    logic [CNT_W:0]   after_pop, sum;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PTR_W-1:0] rd_nxt, wr_nxt, wp1;
    entry_t           e_reg, e_mem, slot0, slot1, head_nxt;

    // Pop is resolved first so its slot is visible to the same-cycle pushes.
    always_comb begin
        pop       = (count != '0) && trc.out_ready;
        r_ev      = (state_q == CAPTURE) && reg_we && (reg_waddr != '0);
        m_ev      = (state_q == CAPTURE) && mem_we;
        after_pop = {1'b0, count} - (CNT_W+1)'(pop);

        e_reg        = '0;
        e_reg.is_mem = 1'b0;
        e_reg.addr   = ADDR_W'(reg_waddr);
        e_reg.data   = reg_wdata;
        e_reg.ts     = ts_q;
        e_mem        = '0;
        e_mem.is_mem = 1'b1;
        e_mem.addr   = ADDR_W'(mem_addr);
        e_mem.data   = mem_wdata;
        e_mem.ts     = ts_q;

        if (WRAP_MODE != 0) begin
            acc_r = r_ev;
            acc_m = m_ev;
        end else begin
            acc_r = r_ev && (after_pop < DEPTH_C);
            acc_m = m_ev && ((after_pop + (CNT_W+1)'(acc_r)) < DEPTH_C);
        end
        drop   = (r_ev && !acc_r) || (m_ev && !acc_m);
        n_push = {1'b0, acc_r} + {1'b0, acc_m};
        sum    = after_pop + (CNT_W+1)'(n_push);

        // Anything past DEPTH can only happen in wrap mode and evicts the oldest entries.
        if (sum > DEPTH_C) begin
            n_ovw   = 2'(sum - DEPTH_C);
            cnt_nxt = CNT_W'(DEPTH);
        end else begin
            n_ovw   = 2'b00;
            cnt_nxt = sum[CNT_W-1:0];
        end
        ovf_set   = drop || (n_ovw != 2'b00);
        full_stop = (WRAP_MODE == 0) && (drop || ((n_push != 2'b00) && (sum == DEPTH_C)));

        slot0  = acc_r ? e_reg : e_mem;
        slot1  = e_mem;
        wr0    = (n_push != 2'b00);
        wr1    = (n_push == 2'd2);
        wp1    = wr_ptr + PTR_W'(1);
        wr_nxt = wr_ptr + PTR_W'(n_push);
        rd_nxt = rd_ptr + PTR_W'(pop) + PTR_W'(n_ovw);

        // Head of the next cycle may be an entry being written on this edge.
        if (cnt_nxt == '0)                 head_nxt = '0;
        else if (wr1 && (rd_nxt == wp1))   head_nxt = slot1;
        else if (wr0 && (rd_nxt == wr_ptr)) head_nxt = slot0;
        else                               head_nxt = buf_q[rd_nxt];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = CAPTURE;
            CAPTURE: if (stop || full_stop) state_d = STOPPED;
            STOPPED: if (start && !stop) state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
            ts_q     <= '0;
            out_q    <= '0;
        end else begin
            ts_q    <= ts_q + 1'b1;
            state_q <= state_d;
            if (clear) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                overflow <= 1'b0;
                out_q    <= '0;
            end else begin
                count  <= cnt_nxt;
                rd_ptr <= rd_nxt;
                wr_ptr <= wr_nxt;
                out_q  <= head_nxt;
                if (ovf_set) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (wr0) buf_q[wr_ptr] <= slot0;
            if (wr1) buf_q[wp1]    <= slot1;
        end
    end

    assign trc.out_valid  = (count != '0);
    assign trc.out_is_mem = out_q.is_mem;
    assign trc.out_addr   = out_q.addr;
    assign trc.out_data   = out_q.data;
    assign trc.out_ts     = out_q.ts;
    assign state          = state_q;
endmodule

// File: tb/tb_proc_trace_buffer.sv
// Directed bench for proc_trace_buffer: three instances (default, DEPTH=4 stop, DEPTH=4 wrap)
// share stimulus; expected entries are queued at drive time and popped on drain.
module tb_proc_trace_buffer;
    typedef struct packed {
        logic        is_mem;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] ts;
    } ent_t;

    logic        clk, reset, start, stop, clear;
    logic        reg_we, mem_we;
    logic [2:0]  reg_waddr;
    logic [7:0]  mem_addr;
    logic [15:0] reg_wdata, mem_wdata;
    logic [2:0]  rdy;
    logic [4:0]  cnt0;
    logic [2:0]  cnt1, cnt2;
    logic [1:0]  st0, st1, st2;
    logic        ovf0, ovf1, ovf2;
    logic [15:0] tb_ts;
    int          tests = 0, fails = 0;
    ent_t        q0[$], q1[$], q2[$];

    proc_trace_buffer_if #(.ADDR_W(8), .DATA_W(16), .TS_W(16)) if0 ();
    proc_trace_buffer_if #(.ADDR_W(8), .DATA_W(16), .TS_W(16)) if1 ();
    proc_trace_buffer_if #(.ADDR_W(8), .DATA_W(16), .TS_W(16)) if2 ();
    assign if0.out_ready = rdy[0];
    assign if1.out_ready = rdy[1];
    assign if2.out_ready = rdy[2];

    proc_trace_buffer #(.DEPTH(16), .WRAP_MODE(0)) u0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .trc(if0), .count(cnt0), .state(st0), .overflow(ovf0));
    proc_trace_buffer #(.DEPTH(4), .WRAP_MODE(0)) u1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .trc(if1), .count(cnt1), .state(st1), .overflow(ovf1));
    proc_trace_buffer #(.DEPTH(4), .WRAP_MODE(1)) u2 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .trc(if2), .count(cnt2), .state(st2), .overflow(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle stamp: cycles since reset release.
    always @(posedge clk or negedge reset)
        if (!reset) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;

    function automatic logic [63:0] vld(input int k);
        case (k) 0: return 64'(if0.out_valid); 1: return 64'(if1.out_valid); default: return 64'(if2.out_valid); endcase
    endfunction
    function automatic logic [63:0] cnt(input int k);
        case (k) 0: return 64'(cnt0); 1: return 64'(cnt1); default: return 64'(cnt2); endcase
    endfunction
    function automatic logic [63:0] st(input int k);
        case (k) 0: return 64'(st0); 1: return 64'(st1); default: return 64'(st2); endcase
    endfunction
    function automatic logic [63:0] ovf(input int k);
        case (k) 0: return 64'(ovf0); 1: return 64'(ovf1); default: return 64'(ovf2); endcase
    endfunction
    function automatic logic [63:0] head(input int k);
        case (k)
            0: return 64'({if0.out_is_mem, if0.out_addr, if0.out_data, if0.out_ts});
            1: return 64'({if1.out_is_mem, if1.out_addr, if1.out_data, if1.out_ts});
            default: return 64'({if2.out_is_mem, if2.out_addr, if2.out_data, if2.out_ts});
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic qpush(input int k, input ent_t e);
        case (k) 0: q0.push_back(e); 1: q1.push_back(e); default: q2.push_back(e); endcase
    endtask
    task automatic qpop(input int k, output ent_t e);
        e = '0;
        case (k)
            0: if (q0.size() > 0) e = q0.pop_front();
            1: if (q1.size() > 0) e = q1.pop_front();
            default: if (q2.size() > 0) e = q2.pop_front();
        endcase
    endtask
    function automatic int qsize(input int k);
        case (k) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
    endfunction

    task automatic pulse_start(); start = 1'b1; step(); start = 1'b0; endtask
    task automatic pulse_stop();  stop  = 1'b1; step(); stop  = 1'b0; endtask
    task automatic pulse_clear(); clear = 1'b1; step(); clear = 1'b0; endtask

    // Drive one cycle of write strobes; rm/mm select which instances must record them.
    task automatic ev(input logic re, input logic [2:0] ra, input logic [15:0] rd,
                      input logic me, input logic [7:0] ma, input logic [15:0] md,
                      input logic [2:0] rm, input logic [2:0] mm);
        reg_we = re; reg_waddr = ra; reg_wdata = rd;
        mem_we = me; mem_addr = ma; mem_wdata = md;
        for (int k = 0; k < 3; k++) begin
            if (rm[k]) qpush(k, '{1'b0, {5'b0, ra}, rd, tb_ts});
            if (mm[k]) qpush(k, '{1'b1, ma, md, tb_ts});
        end
        step();
        reg_we = 1'b0; mem_we = 1'b0;
    endtask

    task automatic chk_head(input int k, input string tag);
        ent_t e;
        qpop(k, e);
        chk($sformatf("%s%0d.valid", tag, k), vld(k), 64'd1);
        chk($sformatf("%s%0d.entry", tag, k), head(k), 64'(e));
    endtask

    task automatic drain(input int k);
        int n;
        n = qsize(k);
        rdy[k] = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk_head(k, "drain");
            step();
        end
        rdy[k] = 1'b0;
        chk($sformatf("drain%0d.empty_count", k), cnt(k), 64'd0);
        chk($sformatf("drain%0d.empty_valid", k), vld(k), 64'd0);
    endtask

    initial begin
        ent_t dummy;
        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; rdy = '0;
        #3;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset%0d.valid", k), vld(k), 64'd0);
            chk($sformatf("reset%0d.count", k), cnt(k), 64'd0);
            chk($sformatf("reset%0d.state", k), st(k), 64'd0);
            chk($sformatf("reset%0d.head", k), head(k), 64'd0);
        end
        chk("reset.overflow", ovf(0), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic capture: reg write at ts=10, mem write at ts=12
        pulse_start();
        for (int i = 0; i < 20 && tb_ts != 16'd10; i++) step();
        chk("basic.ts_reached", 64'(tb_ts), 64'd10);
        ev(1'b1, 3'd3, 16'h0005, 1'b0, 8'h00, 16'h0000, 3'b111, 3'b000);
        step();
        ev(1'b0, 3'd0, 16'h0000, 1'b1, 8'h08, 16'h0005, 3'b000, 3'b111);
        chk("basic.count", cnt(0), 64'd2);
        for (int k = 0; k < 3; k++) drain(k);
        chk("basic.overflow", ovf(0), 64'd0);

        // $0 filter, then strobes in STOPPED and IDLE are ignored
        pulse_start();
        ev(1'b1, 3'd0, 16'hDEAD, 1'b0, 8'h00, 16'h0000, 3'b000, 3'b000);
        chk("filter.valid", vld(0), 64'd0);
        pulse_stop();
        chk("filter.stopped", st(0), 64'd2);
        ev(1'b1, 3'd4, 16'h1111, 1'b1, 8'h20, 16'h2222, 3'b000, 3'b000);
        chk("filter.stopped_valid", vld(0), 64'd0);
        pulse_clear();
        chk("filter.idle", st(0), 64'd0);
        ev(1'b1, 3'd4, 16'h2222, 1'b1, 8'h10, 16'h3333, 3'b000, 3'b000);
        chk("filter.idle_valid", vld(0), 64'd0);
        chk("filter.idle_count", cnt(0), 64'd0);

        // Dual event: register entry first, then memory entry, same ts
        pulse_start();
        ev(1'b1, 3'd5, 16'hAAAA, 1'b1, 8'h33, 16'h1234, 3'b111, 3'b111);
        chk("dual.count", cnt(0), 64'd2);
        for (int k = 0; k < 3; k++) drain(k);
        pulse_clear();

        // Fill to DEPTH=4: stop instance halts, wrap instance keeps capturing
        pulse_start();
        for (int i = 1; i <= 4; i++)
            ev(1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 8'h00, 16'h0000, 3'b111, 3'b000);
        chk("full.stop_state", st(1), 64'd2);
        chk("full.stop_count", cnt(1), 64'd4);
        chk("full.stop_ovf", ovf(1), 64'd0);
        chk("full.wrap_state", st(2), 64'd1);
        chk("full.wrap_count", cnt(2), 64'd4);
        pulse_start();
        chk("full.resume", st(1), 64'd1);
        ev(1'b1, 3'd5, 16'h0105, 1'b0, 8'h00, 16'h0000, 3'b101, 3'b000);
        qpop(2, dummy);
        chk("full.drop_ovf", ovf(1), 64'd1);
        chk("full.drop_state", st(1), 64'd2);
        chk("full.drop_count", cnt(1), 64'd4);
        chk("full.wrap_ovf", ovf(2), 64'd1);
        chk("full.wrap_state2", st(2), 64'd1);
        ev(1'b1, 3'd6, 16'h0106, 1'b0, 8'h00, 16'h0000, 3'b101, 3'b000);
        qpop(2, dummy);
        chk("full.wrap_count2", cnt(2), 64'd4);
        chk("full.big_count", cnt(0), 64'd6);
        chk("full.big_ovf", ovf(0), 64'd0);
        for (int k = 0; k < 3; k++) drain(k);
        pulse_clear();
        chk("clear.ovf1", ovf(1), 64'd0);
        chk("clear.ovf2", ovf(2), 64'd0);
        chk("clear.state1", st(1), 64'd0);

        // Pop and push on the same edge while full
        pulse_start();
        for (int i = 7; i <= 10; i++)
            ev(1'b1, 3'(i - 6), 16'h0100 + 16'(i), 1'b0, 8'h00, 16'h0000, 3'b111, 3'b000);
        pulse_start();
        rdy[1] = 1'b1; rdy[2] = 1'b1;
        chk_head(1, "popush");
        chk_head(2, "popush");
        ev(1'b1, 3'd3, 16'h010B, 1'b0, 8'h00, 16'h0000, 3'b111, 3'b000);
        rdy[1] = 1'b0; rdy[2] = 1'b0;
        chk("popush.count1", cnt(1), 64'd4);
        chk("popush.ovf1", ovf(1), 64'd0);
        chk("popush.state1", st(1), 64'd2);
        chk("popush.count2", cnt(2), 64'd4);
        chk("popush.ovf2", ovf(2), 64'd0);
        chk("popush.count0", cnt(0), 64'd5);

        // One free slot, two events: register kept, memory dropped (stop); both evict (wrap)
        rdy[1] = 1'b1;
        chk_head(1, "onefree");
        step();
        rdy[1] = 1'b0;
        chk("onefree.count1", cnt(1), 64'd3);
        pulse_start();
        ev(1'b1, 3'd6, 16'h010C, 1'b1, 8'h44, 16'h010D, 3'b111, 3'b101);
        qpop(2, dummy);
        qpop(2, dummy);
        chk("onefree.count1b", cnt(1), 64'd4);
        chk("onefree.ovf1", ovf(1), 64'd1);
        chk("onefree.state1", st(1), 64'd2);
        chk("onefree.count2", cnt(2), 64'd4);
        chk("onefree.ovf2", ovf(2), 64'd1);
        chk("onefree.count0", cnt(0), 64'd7);
        drain(1);
        drain(2);

        // Clear while draining
        rdy[0] = 1'b1;
        chk_head(0, "middrain");
        step();
        chk_head(0, "middrain");
        clear = 1'b1;
        step();
        clear = 1'b0; rdy[0] = 1'b0;
        q0.delete();
        chk("middrain.count", cnt(0), 64'd0);
        chk("middrain.valid", vld(0), 64'd0);
        chk("middrain.state", st(0), 64'd0);

        // Asynchronous reset in the middle of capture
        pulse_start();
        ev(1'b1, 3'd2, 16'hBEEF, 1'b1, 8'h55, 16'hCAFE, 3'b000, 3'b000);
        chk("async.pre_count", cnt(0), 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("async.valid", vld(0), 64'd0);
        chk("async.count", cnt(0), 64'd0);
        chk("async.state", st(0), 64'd0);
        chk("async.head", head(0), 64'd0);
        chk("async.count2", cnt(2), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/proc_trace_buffer.md
Name: proc_trace_buffer

Overview:
- Synthesizable write-trace capture block for the 16-bit MIPS processor core.
- Taps the register-file writeback port and the data-memory write port.
- Timestamps every architectural write and stores it in a parametrised circular buffer.
- A valid/ready interface drains the buffer, so architectural state can be checked in simulation or on silicon without probing the internal register or memory arrays.

Parameters:
DATA_W, 16, width of register/memory data
REG_AW, 3, register-file address width
MEM_AW, 8, data-memory address width
DEPTH, 16, entry count; power of two, ≥4
TS_W, 16, timestamp width
WRAP_MODE, 0, 0 = stop on full; 1 = overwrite oldest

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; begin capture
stop  in  1  pulse; end capture
clear  in  1  pulse; flush buffer, return to IDLE
reg_we  in  1  register write strobe
reg_waddr  in  REG_AW  register write address
reg_wdata  in  DATA_W  register write data
mem_we  in  1  data-memory write strobe
mem_addr  in  MEM_AW  memory write address
mem_wdata  in  DATA_W  memory write data
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_is_mem  out  1  0 = register entry, 1 = memory entry
out_addr  out  max(REG_AW,MEM_AW)  zero-extended address
out_data  out  DATA_W  written value
out_ts  out  TS_W  cycle stamp of the write
count  out  clog2(DEPTH+1)  occupied entries
state  out  2  00 IDLE, 01 CAPTURE, 10 STOPPED
overflow  out  1  sticky; an entry was dropped or overwritten

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, pointers=0, overflow=0, timestamp=0.
  - out_valid=0; out_is_mem/out_addr/out_data/out_ts=0.
- Timestamp: free-running TS_W counter, +1 every cycle in all states, wraps modulo 2^TS_W. An entry stores the counter value of the cycle its strobe is sampled.
- State machine (control priority: clear > stop > start):
  - IDLE: start → CAPTURE. Strobes are ignored.
  - CAPTURE: stop → STOPPED. With WRAP_MODE=0, a push that fills the buffer or drops an entry → STOPPED on the same edge.
  - STOPPED: start → CAPTURE, with contents retained. Strobes are ignored.
  - clear in any state: count=0, pointers=0, overflow=0, state=IDLE. Any same-cycle push or pop is discarded.
- Capture filter: reg_we with reg_waddr==0 is not recorded ($0 is hardwired).
- Two events in one cycle: register entry is written first, memory entry second (up to two pushes per cycle).
- Pop: out_valid && out_ready on a rising edge removes the head entry.
  - Pop is evaluated before push, so the freed slot is available to a same-cycle push.
- Full handling:
  - WRAP_MODE=0: pushes beyond the free slots are dropped; overflow=1. With one free slot and two events, the register entry is kept and the memory entry dropped.
  - WRAP_MODE=1: each excess push overwrites the oldest entry and advances the head; overflow=1; count stays DEPTH.
- Output timing:
  - out_* is registered from the head; it presents the new head the cycle after a pop.
  - out_valid = (count≠0), readable in every state including IDLE.
  - out_* is held stable while out_valid=1 and out_ready=0.
- count updates on the same edge as push/pop: net change −1..+2, saturates at DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Overflow clears only on reset or clear.

Test Plan:
- Basic capture: reset, start, then reg write $3=16'h0005 at ts=10 and mem[8]=16'h0005 at ts=12, out_ready=1 → two entries in order {0,3,0005,10} then {1,8,0005,12}; count returns to 0; overflow=0.
- Filter and idle: reg write to $0, then reg writes while IDLE → no entries; out_valid stays 0.
- Dual event: reg_we and mem_we in the same cycle → register entry first, then memory entry, both with the same ts; count +2.
- Stop-on-full (WRAP_MODE=0, DEPTH=4): 5 reg writes with out_ready=0 → count=4; state=STOPPED after the 4th write; overflow=1 after the 5th; drained data = writes 1–4.
- Wrap (WRAP_MODE=1, DEPTH=4): 6 writes, no drain → count=4; state=CAPTURE; overflow=1; drained data = writes 3–6.
- Concurrency and reset: pop+push while full → count unchanged, no overflow; clear mid-drain → count=0, out_valid=0, state=IDLE; reset asserted mid-capture → all outputs zero immediately, without waiting for a clock edge.
